// File: rtl/m68k_bus_pkg.sv
// Shared types and the default decode table for the 68k bus region decoder.
package m68k_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_ERR,
    S_RELEASE
  } state_e;

  localparam int REGION_IDX_W    = 4;
  localparam int DEF_NUM_REGIONS = 8;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_WS_W        = 4;

  // Index order: 0 ROM, 1 RAM, 2 IO, 3 CAN, 4 DRAM. Slots 5..7 repeat ROM and are
  // shadowed by region 0, so they can never be selected.
  localparam logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_BASE = {
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0800_0000,
    32'h0050_0000, 32'h0040_0000, 32'hF000_0000, 32'h0000_0000
  };
  localparam logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_MASK = {
    32'hFFFF_8000, 32'hFFFF_8000, 32'hFFFF_8000, 32'hFC00_0000,
    32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFC_0000, 32'hFFFF_8000
  };
  localparam logic [DEF_NUM_REGIONS*DEF_WS_W-1:0] DEF_REGION_WAIT = {
    4'd2, 4'd2, 4'd2, 4'd0, 4'd0, 4'd3, 4'd1, 4'd2
  };
  localparam logic [DEF_NUM_REGIONS-1:0] DEF_REGION_EXT = 8'b0001_0000;

endpackage

// File: rtl/region_match.sv
// Combinational base/mask window compare with fixed lowest-index-wins priority.
module region_match
  import m68k_bus_pkg::*;
#(
  parameter int                            NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int                            ADDR_W      = DEF_ADDR_W,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK
) (
  input  logic [ADDR_W-1:0]       addr_i,
  output logic                    hit_o,
  output logic [REGION_IDX_W-1:0] idx_o
);

  logic [NUM_REGIONS-1:0] hit_vec;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_cmp
    localparam logic [ADDR_W-1:0] BASE = REGION_BASE[g*ADDR_W +: ADDR_W];
    localparam logic [ADDR_W-1:0] MASK = REGION_MASK[g*ADDR_W +: ADDR_W];
    assign hit_vec[g] = (((addr_i ^ BASE) & MASK) == '0);
  end

  always_comb begin
    idx_o = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit_vec[i]) idx_o = REGION_IDX_W'(i);
    end
  end

  assign hit_o = |hit_vec;

endmodule

// File: rtl/m68k_region_decoder.sv
// 68k bus-cycle FSM: latches chip selects, times DTACK per region, raises BERR on
// unmapped access or timeout.
module m68k_region_decoder
  import m68k_bus_pkg::*;
#(
  parameter int                            NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int                            ADDR_W      = DEF_ADDR_W,
  parameter int                            WS_W        = DEF_WS_W,
  parameter int                            TIMEOUT_CYC = 255,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
  parameter logic [NUM_REGIONS*WS_W-1:0]   REGION_WAIT = DEF_REGION_WAIT,
  parameter logic [NUM_REGIONS-1:0]        REGION_EXT  = DEF_REGION_EXT
) (
  input  logic                    Clk,
  input  logic                    Reset_H,
  input  logic [ADDR_W-1:0]       Address,
  input  logic                    AS_L,
  input  logic                    ExtDtack_L,
  output logic [NUM_REGIONS-1:0]  Select_H,
  output logic [REGION_IDX_W-1:0] RegionIdx,
  output logic                    Dtack_L,
  output logic                    Berr_L,
  output logic                    Busy_H
);

  localparam int                TCNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);

  state_e                  state_q, state_d;
  logic [NUM_REGIONS-1:0]  sel_q, sel_d;
  logic [REGION_IDX_W-1:0] idx_q, idx_d;
  logic                    ext_q, ext_d;
  logic [WS_W-1:0]         wcnt_q, wcnt_d;
  logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
  logic                    armed_q, armed_d;
  logic                    dtack_q, dtack_d;
  logic                    berr_q, berr_d;

  logic                    match_hit;
  logic [REGION_IDX_W-1:0] match_idx;
  logic [NUM_REGIONS-1:0]  dec_sel;
  logic [WS_W-1:0]         dec_wait;
  logic                    dec_ext;

  region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_match (
    .addr_i (Address),
    .hit_o  (match_hit),
    .idx_o  (match_idx)
  );

  always_comb begin
    dec_sel  = '0;
    dec_wait = '0;
    dec_ext  = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (match_idx == REGION_IDX_W'(i)) begin
        dec_sel[i] = match_hit;
        dec_wait   = REGION_WAIT[i*WS_W +: WS_W];
        dec_ext    = REGION_EXT[i];
      end
    end
  end

  // A new cycle starts only after AS_L has been seen high since the last decode,
  // so an AS_L held low across reset cannot start a stray cycle.
  assign armed_d = AS_L | (armed_q & ~((state_q == S_IDLE) & ~AS_L));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    ext_d   = ext_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (!AS_L && armed_q) begin
          if (match_hit) begin
            state_d = S_WAIT;
            sel_d   = dec_sel;
            idx_d   = match_idx;
            ext_d   = dec_ext;
            wcnt_d  = dec_wait;
            tcnt_d  = '0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_WAIT: begin
        if (tcnt_q != '1) tcnt_d = tcnt_q + 1'b1;
        // Abort beats timeout beats acknowledge.
        if (AS_L) begin
          state_d = S_RELEASE;
          sel_d   = '0;
        end else if (tcnt_q == TCNT_LAST) begin
          state_d = S_ERR;
          sel_d   = '0;
        end else if (ext_q) begin
          if (!ExtDtack_L) state_d = S_ACK;
        end else if (wcnt_q == '0) begin
          state_d = S_ACK;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      S_ACK: begin
        if (AS_L) begin
          state_d = S_RELEASE;
          sel_d   = '0;
        end
      end
      S_ERR: begin
        if (AS_L) state_d = S_RELEASE;
      end
      S_RELEASE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // Strobes follow the registered state one cycle later and drop as soon as AS_L rises.
  assign dtack_d = ~((state_q == S_ACK) & ~AS_L);
  assign berr_d  = ~((state_q == S_ERR) & ~AS_L);

  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      ext_q   <= 1'b0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      armed_q <= 1'b0;
      dtack_q <= 1'b1;
      berr_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      ext_q   <= ext_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      armed_q <= armed_d;
      dtack_q <= dtack_d;
      berr_q  <= berr_d;
    end
  end

  assign Select_H  = sel_q;
  assign RegionIdx = idx_q;
  assign Dtack_L   = dtack_q;
  assign Berr_L    = berr_q;
  assign Busy_H    = (state_q != S_IDLE);

endmodule

// File: tb/tb_m68k_region_decoder.sv
// Directed bench for m68k_region_decoder: default table plus an overlapping-window instance.
module tb_m68k_region_decoder;

  logic        Clk = 1'b0;
  logic        Reset_H;
  logic [31:0] Address;
  logic        AS_L;
  logic        ExtDtack_L;

  logic [7:0]  Select_H;
  logic [3:0]  RegionIdx;
  logic        Dtack_L, Berr_L, Busy_H;

  logic [4:0]  ov_sel;
  logic [3:0]  ov_idx;
  logic        ov_dtack, ov_berr, ov_busy;

  int checks = 0;
  int errors = 0;

  logic [14:0] obs;
  logic [10:0] obs_s;
  assign obs   = {Select_H, RegionIdx, Dtack_L, Berr_L, Busy_H};
  assign obs_s = {Select_H, Dtack_L, Berr_L, Busy_H};

  always #5 Clk = ~Clk;

  m68k_region_decoder dut (
    .Clk        (Clk),
    .Reset_H    (Reset_H),
    .Address    (Address),
    .AS_L       (AS_L),
    .ExtDtack_L (ExtDtack_L),
    .Select_H   (Select_H),
    .RegionIdx  (RegionIdx),
    .Dtack_L    (Dtack_L),
    .Berr_L     (Berr_L),
    .Busy_H     (Busy_H)
  );

  // Regions 1 and 4 both cover 0040_0000.
  m68k_region_decoder #(
    .NUM_REGIONS (5),
    .REGION_BASE ({32'h0040_0000, 32'h0050_0000, 32'h0080_0000, 32'h0040_0000, 32'h0000_0000}),
    .REGION_MASK ({32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_8000}),
    .REGION_WAIT ({4'd0, 4'd0, 4'd0, 4'd1, 4'd0}),
    .REGION_EXT  (5'b00000)
  ) dut_ov (
    .Clk        (Clk),
    .Reset_H    (Reset_H),
    .Address    (Address),
    .AS_L       (AS_L),
    .ExtDtack_L (ExtDtack_L),
    .Select_H   (ov_sel),
    .RegionIdx  (ov_idx),
    .Dtack_L    (ov_dtack),
    .Berr_L     (ov_berr),
    .Busy_H     (ov_busy)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic bus_idle();
    AS_L = 1'b1;
    ExtDtack_L = 1'b1;
    step(); step(); step();
  endtask

  task automatic test_reset();
    Reset_H = 1'b1; AS_L = 1'b1; ExtDtack_L = 1'b1; Address = '0;
    step(); step();
    checks++;
    if (obs !== {8'h00, 4'd0, 3'b110}) begin
      errors++; $display("FAIL reset_initial: got %h exp %h", obs, {8'h00, 4'd0, 3'b110});
    end
    Reset_H = 1'b0;
    step();
    Address = 32'h0000_1234; AS_L = 1'b0;
    step(); step();
    checks++;
    if (obs !== {8'h01, 4'd0, 3'b111}) begin
      errors++; $display("FAIL reset_precycle: got %h exp %h", obs, {8'h01, 4'd0, 3'b111});
    end
    Reset_H = 1'b1;
    step();
    checks++;
    if (obs !== {8'h00, 4'd0, 3'b110}) begin
      errors++; $display("FAIL reset_midcycle: got %h exp %h", obs, {8'h00, 4'd0, 3'b110});
    end
    Reset_H = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (obs !== {8'h00, 4'd0, 3'b110}) begin
        errors++; $display("FAIL reset_no_restart: cyc %0d got %h exp %h", k, obs, {8'h00, 4'd0, 3'b110});
      end
    end
    bus_idle();
  endtask

  task automatic test_rom_wait();
    Address = 32'h0000_1234; AS_L = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs !== {8'h01, 4'd0, 3'b111}) begin
        errors++; $display("FAIL rom_wait: cyc %0d got %h exp %h", k, obs, {8'h01, 4'd0, 3'b111});
      end
      step();
    end
    checks++;
    if (obs !== {8'h01, 4'd0, 3'b011}) begin
      errors++; $display("FAIL rom_dtack_cyc4: got %h exp %h", obs, {8'h01, 4'd0, 3'b011});
    end
    AS_L = 1'b1;
    step();
    checks++;
    if (obs_s !== {8'h00, 3'b111}) begin
      errors++; $display("FAIL rom_release: got %h exp %h", obs_s, {8'h00, 3'b111});
    end
    step();
    checks++;
    if (obs_s !== {8'h00, 3'b110}) begin
      errors++; $display("FAIL rom_idle: got %h exp %h", obs_s, {8'h00, 3'b110});
    end
    bus_idle();
  endtask

  task automatic test_can_nowait();
    Address = 32'h0050_0010; AS_L = 1'b0;
    step();
    checks++;
    if (obs !== {8'h08, 4'd3, 3'b111}) begin
      errors++; $display("FAIL can_decode: got %h exp %h", obs, {8'h08, 4'd3, 3'b111});
    end
    Address = 32'h3000_0000;
    step();
    checks++;
    if (obs !== {8'h08, 4'd3, 3'b111}) begin
      errors++; $display("FAIL can_addr_hold: got %h exp %h", obs, {8'h08, 4'd3, 3'b111});
    end
    step();
    checks++;
    if (obs !== {8'h08, 4'd3, 3'b011}) begin
      errors++; $display("FAIL can_dtack_cyc2: got %h exp %h", obs, {8'h08, 4'd3, 3'b011});
    end
    bus_idle();
  endtask

  task automatic test_ext_dtack();
    Address = 32'h0900_0000; AS_L = 1'b0; ExtDtack_L = 1'b1;
    step();
    for (int k = 0; k <= 10; k++) begin
      if (k == 10) ExtDtack_L = 1'b0;
      checks++;
      if (obs !== {8'h10, 4'd4, 3'b111}) begin
        errors++; $display("FAIL ext_wait: cyc %0d got %h exp %h", k, obs, {8'h10, 4'd4, 3'b111});
      end
      step();
    end
    checks++;
    if (obs !== {8'h10, 4'd4, 3'b111}) begin
      errors++; $display("FAIL ext_ack_edge: got %h exp %h", obs, {8'h10, 4'd4, 3'b111});
    end
    step();
    checks++;
    if (obs !== {8'h10, 4'd4, 3'b011}) begin
      errors++; $display("FAIL ext_dtack: got %h exp %h", obs, {8'h10, 4'd4, 3'b011});
    end
    bus_idle();
  endtask

  task automatic test_timeout();
    Address = 32'h0900_0000; AS_L = 1'b0; ExtDtack_L = 1'b1;
    step();
    for (int k = 1; k <= 254; k++) begin
      step();
      checks++;
      if (obs !== {8'h10, 4'd4, 3'b111}) begin
        errors++; $display("FAIL timeout_wait: cyc %0d got %h exp %h", k, obs, {8'h10, 4'd4, 3'b111});
      end
    end
    step();
    checks++;
    if (obs !== {8'h00, 4'd4, 3'b111}) begin
      errors++; $display("FAIL timeout_err_entry: got %h exp %h", obs, {8'h00, 4'd4, 3'b111});
    end
    step();
    checks++;
    if (obs !== {8'h00, 4'd4, 3'b101}) begin
      errors++; $display("FAIL timeout_berr: got %h exp %h", obs, {8'h00, 4'd4, 3'b101});
    end
    AS_L = 1'b1;
    step();
    checks++;
    if (obs_s !== {8'h00, 3'b111}) begin
      errors++; $display("FAIL timeout_release: got %h exp %h", obs_s, {8'h00, 3'b111});
    end
    bus_idle();
  endtask

  task automatic test_unmapped();
    Address = 32'h3000_0000; AS_L = 1'b0;
    step();
    checks++;
    if (obs_s !== {8'h00, 3'b111}) begin
      errors++; $display("FAIL unmapped_decode: got %h exp %h", obs_s, {8'h00, 3'b111});
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (obs_s !== {8'h00, 3'b101}) begin
        errors++; $display("FAIL unmapped_berr: cyc %0d got %h exp %h", k, obs_s, {8'h00, 3'b101});
      end
    end
    AS_L = 1'b1;
    step();
    checks++;
    if (obs_s !== {8'h00, 3'b111}) begin
      errors++; $display("FAIL unmapped_release: got %h exp %h", obs_s, {8'h00, 3'b111});
    end
    step();
    checks++;
    if (obs_s !== {8'h00, 3'b110}) begin
      errors++; $display("FAIL unmapped_idle: got %h exp %h", obs_s, {8'h00, 3'b110});
    end
    bus_idle();
  endtask

  task automatic test_overlap_abort();
    Address = 32'h0040_0000; AS_L = 1'b0;
    step();
    checks++;
    if ({ov_sel, ov_idx, ov_busy} !== {5'b00010, 4'd1, 1'b1}) begin
      errors++; $display("FAIL overlap_priority: got %h exp %h", {ov_sel, ov_idx, ov_busy}, {5'b00010, 4'd1, 1'b1});
    end
    checks++;
    if (obs !== {8'h04, 4'd2, 3'b111}) begin
      errors++; $display("FAIL io_decode: got %h exp %h", obs, {8'h04, 4'd2, 3'b111});
    end
    AS_L = 1'b1;
    step();
    checks++;
    if ({ov_sel, ov_dtack, ov_berr, ov_busy, obs_s} !== {5'b00000, 3'b111, 8'h00, 3'b111}) begin
      errors++; $display("FAIL abort_release: got %h exp %h", {ov_sel, ov_dtack, ov_berr, ov_busy, obs_s}, {5'b00000, 3'b111, 8'h00, 3'b111});
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({ov_dtack, ov_berr, ov_busy, Dtack_L, Berr_L, Busy_H} !== 6'b110110) begin
        errors++; $display("FAIL abort_no_strobe: cyc %0d got %b exp %b", k, {ov_dtack, ov_berr, ov_busy, Dtack_L, Berr_L, Busy_H}, 6'b110110);
      end
    end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    Address = 32'h0050_0010; AS_L = 1'b0;
    step(); step(); step();
    checks++;
    if (obs !== {8'h08, 4'd3, 3'b011}) begin
      errors++; $display("FAIL b2b_first_dtack: got %h exp %h", obs, {8'h08, 4'd3, 3'b011});
    end
    AS_L = 1'b1;
    step();
    AS_L = 1'b0;
    checks++;
    if (obs_s !== {8'h00, 3'b111}) begin
      errors++; $display("FAIL b2b_release: got %h exp %h", obs_s, {8'h00, 3'b111});
    end
    step();
    checks++;
    if (obs_s !== {8'h00, 3'b110}) begin
      errors++; $display("FAIL b2b_gap: got %h exp %h", obs_s, {8'h00, 3'b110});
    end
    step();
    checks++;
    if (obs !== {8'h08, 4'd3, 3'b111}) begin
      errors++; $display("FAIL b2b_second_decode: got %h exp %h", obs, {8'h08, 4'd3, 3'b111});
    end
    step(); step();
    checks++;
    if (obs !== {8'h08, 4'd3, 3'b011}) begin
      errors++; $display("FAIL b2b_second_dtack: got %h exp %h", obs, {8'h08, 4'd3, 3'b011});
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_rom_wait();
    test_can_nowait();
    test_ext_dtack();
    test_timeout();
    test_unmapped();
    test_overlap_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
